// File: rtl/conv_pkg.sv
// Shared types and default sizing for the conv weight ROM read path.
package conv_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int CNT_W          = DEF_ADDR_WIDTH + 1;
    localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } rd_state_e;

endpackage

// File: rtl/conv_weight_fifo.sv
// Small synchronous FIFO holding {last, data} words between the ROM and the conv engine.
module conv_weight_fifo
    import conv_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 1 << PTR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [ptr_w-1:0] wr_ptr_reg;
    logic [ptr_w-1:0] rd_ptr_reg;
    logic [ptr_w:0]   count_reg;
    logic             do_wr;
    logic             do_rd;

    // The reader's credit check keeps writes off a full FIFO; the guard is a backstop.
    assign do_wr = wr_en && (count_reg != (ptr_w + 1)'(DEPTH));
    assign do_rd = rd_en && (count_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                mem_reg[wr_ptr_reg] <= wr_data;
                wr_ptr_reg          <= wr_ptr_reg + ptr_w'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_w'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (ptr_w + 1)'(1);
                2'b01:   count_reg <= count_reg - (ptr_w + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/conv_weight_rom_reader.sv
// Streams LEN consecutive weight ROM words from BASE to the conv engine over valid/ready,
// hiding the ROM read latency behind a credit-checked output FIFO.
module conv_weight_rom_reader
    import conv_pkg::*;
#(
    parameter int ADDR_WIDTH = CNT_W - 1,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_rd_oce,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int cnt_w = ADDR_WIDTH + 1;
    localparam int ptr_w = $clog2(FIFO_DEPTH);
    localparam int sum_w = ptr_w + 2;

    rd_state_e             state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [cnt_w-1:0]      len_reg;
    logic [cnt_w-1:0]      issued_reg;
    logic [RD_LATENCY-1:0] flag_reg, flag_next;
    logic [RD_LATENCY-1:0] last_reg, last_next;
    logic [ptr_w:0]        fifo_count;
    logic [sum_w-1:0]      inflight;
    logic [DATA_WIDTH:0]   fifo_rd_data;
    logic                  issue;
    logic                  issue_last;
    logic                  accept_start;
    logic                  credit_ok;
    logic                  pop;

    assign accept_start = (state_reg == IDLE) && start;
    assign pop          = m_valid && m_ready;
    assign issue_last   = (issued_reg == (len_reg - cnt_w'(1)));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + sum_w'(flag_reg[i]);
        end
    end

    // Every word already in the FIFO or still inside the ROM pipe holds one slot.
    assign credit_ok = (sum_w'(fifo_count) + inflight) < sum_w'(FIFO_DEPTH);

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issued_reg == len_reg) begin
                    state_next = DRAIN;
                end else begin
                    issue = credit_ok;
                end
            end
            DRAIN: begin
                // Leave on the edge that hands off the final word so done follows it directly.
                if ((inflight == '0) &&
                    ((fifo_count == '0) || ((fifo_count == (ptr_w + 1)'(1)) && pop))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Issue flags ride alongside the ROM pipeline; the exiting flag marks valid rom_rd_data.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_track
            if (gi == 0) begin : g_head
                assign flag_next[gi] = issue;
                assign last_next[gi] = issue && issue_last;
            end else begin : g_tail
                assign flag_next[gi] = flag_reg[gi-1];
                assign last_next[gi] = last_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            len_reg    <= '0;
            issued_reg <= '0;
            flag_reg   <= '0;
            last_reg   <= '0;
        end else begin
            state_reg <= state_next;
            flag_reg  <= flag_next;
            last_reg  <= last_next;
            if (accept_start) begin
                addr_reg   <= base_addr;
                len_reg    <= len;
                issued_reg <= '0;
            end else if (issue) begin
                addr_reg   <= addr_reg + ADDR_WIDTH'(1);
                issued_reg <= issued_reg + cnt_w'(1);
            end
        end
    end

    conv_weight_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (flag_reg[RD_LATENCY-1]),
        .wr_data ({last_reg[RD_LATENCY-1], rom_rd_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count)
    );

    assign rom_addr   = addr_reg;
    assign rom_rd_oce = issue || (|flag_reg);
    assign busy       = (state_reg == FETCH) || (state_reg == DRAIN);
    assign done       = (state_reg == DONE);
    assign m_valid    = (fifo_count != '0);
    assign m_data     = fifo_rd_data[DATA_WIDTH-1:0];
    assign m_last     = fifo_rd_data[DATA_WIDTH];

endmodule

// File: tb/tb_conv_weight_rom_reader.sv
// Bench for conv_weight_rom_reader: one instance per ROM latency, a ROM model each,
// and a scoreboard of expected words checked as they are handed off.
`timescale 1ns/1ps
module tb_conv_weight_rom_reader;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NI = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;

    logic          busy [NI];
    logic          done [NI];
    logic          rom_rd_oce [NI];
    logic          m_valid [NI];
    logic          m_last [NI];
    logic [AW-1:0] rom_addr [NI];
    logic [DW-1:0] rom_rd_data [NI];
    logic [DW-1:0] m_data [NI];

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW:0] q0 [$];
    logic [DW:0] q1 [$];
    int   done_cnt [NI];
    int   words [NI];
    int   xfer_words [NI];
    int   last_hs [NI];
    int   cyc_n = 0;
    logic prev_stall [NI];
    logic prev_done [NI];
    logic [DW:0] prev_word [NI];
    logic [DW:0] mon_got;
    logic [DW:0] mon_exp;
    int   mon_qs;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return {6'h2A, a, ~a, 6'h15};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            logic [DW-1:0] rom_q1;
            conv_weight_rom_reader #(
                .ADDR_WIDTH (AW),
                .DATA_WIDTH (DW),
                .RD_LATENCY (gi + 1),
                .FIFO_DEPTH (4)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .start       (start),
                .base_addr   (base_addr),
                .len         (len),
                .busy        (busy[gi]),
                .done        (done[gi]),
                .rom_addr    (rom_addr[gi]),
                .rom_rd_oce  (rom_rd_oce[gi]),
                .rom_rd_data (rom_rd_data[gi]),
                .m_valid     (m_valid[gi]),
                .m_data      (m_data[gi]),
                .m_last      (m_last[gi]),
                .m_ready     (m_ready)
            );
            always @(posedge clk) rom_q1 <= rom_f(rom_addr[gi]);
            if (gi == 0) begin : g_l1
                assign rom_rd_data[gi] = rom_q1;
            end else begin : g_l2
                logic [DW-1:0] rom_q2;
                always @(posedge clk) rom_q2 <= rom_q1;
                assign rom_rd_data[gi] = rom_q2;
            end
        end
    endgenerate

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h exp %h", name, inst, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] b, input logic [AW:0] l);
        logic [AW-1:0] a;
        for (int k = 0; k < int'(l); k++) begin
            a = b + AW'(k);
            q0.push_back({(k == int'(l) - 1), rom_f(a)});
            q1.push_back({(k == int'(l) - 1), rom_f(a)});
        end
    endtask

    task automatic check_idle(input string name);
        for (int i = 0; i < NI; i++) begin
            chk({name, "_flags"}, i, {busy[i], done[i], rom_rd_oce[i], m_valid[i], m_last[i]}, 0);
            chk({name, "_addr"}, i, rom_addr[i], 0);
            chk({name, "_data"}, i, m_data[i], 0);
        end
    endtask

    // Scoreboard monitor: one line per failed transfer check, sampled mid-cycle.
    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                prev_stall[i] = 1'b0;
                prev_done[i]  = 1'b0;
                words[i]      = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                mon_got = {m_last[i], m_data[i]};
                if (prev_stall[i]) chk("stall_hold", i, {m_valid[i], mon_got}, {1'b1, prev_word[i]});
                if (m_valid[i] && m_ready) begin
                    mon_qs = (i == 0) ? q0.size() : q1.size();
                    chk("sb_avail", i, (mon_qs != 0), 1);
                    if (mon_qs != 0) begin
                        if (i == 0) mon_exp = q0.pop_front();
                        else        mon_exp = q1.pop_front();
                        chk("word", i, mon_got, mon_exp);
                    end
                    words[i]++;
                    xfer_words[i]++;
                    last_hs[i] = cyc_n;
                end
                if (done[i]) begin
                    chk("done_pulse", i, prev_done[i], 0);
                    if (words[i] > 0) chk("done_lat", i, cyc_n, last_hs[i] + 1);
                    done_cnt[i]++;
                    words[i] = 0;
                end
                prev_done[i]  = done[i];
                prev_stall[i] = m_valid[i] && !m_ready;
                prev_word[i]  = mon_got;
            end
        end
    end

    task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] l, input int mode, input int exp_words);
        int d0;
        int d1;
        int n;
        push_exp(b, l);
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        xfer_words[0] = 0;
        xfer_words[1] = 0;
        base_addr = b;
        len       = l;
        start     = 1'b1;
        m_ready   = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while ((done_cnt[0] == d0 || done_cnt[1] == d1) && n < 3000) begin
            case (mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready   = (n >= 8 && n < 18) ? 1'b0 : 1'($urandom_range(0, 1));
                    start     = (n == 3);
                    base_addr = 10'h2AA;
                    len       = 11'd3;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            n++;
        end
        start = 1'b0;
        chk("xfer_timeout", 0, (n < 3000), 1);
        chk("xfer_drained", 0, q0.size(), 0);
        chk("xfer_drained", 1, q1.size(), 0);
        for (int i = 0; i < NI; i++) chk("xfer_words", i, xfer_words[i], exp_words);
        m_ready = 1'b1;
        tick();
        tick();
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            mode;
        int            exp_words;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time exhausted");
        $fatal(1);
    end

    initial begin : main
        int n;
        vecs[0] = '{base: 10'h010, len: 11'd8,  mode: 0, exp_words: 8};
        vecs[1] = '{base: 10'h3FE, len: 11'd4,  mode: 0, exp_words: 4};
        vecs[2] = '{base: 10'h100, len: 11'd16, mode: 1, exp_words: 16};
        vecs[3] = '{base: 10'h000, len: 11'd1,  mode: 0, exp_words: 1};
        vecs[4] = '{base: 10'h3F0, len: 11'd40, mode: 2, exp_words: 40};
        vecs[5] = '{base: 10'h3FF, len: 11'd2,  mode: 1, exp_words: 2};

        rst = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // Cycle-exact timing of an 8-word burst at full throughput.
        push_exp(10'h010, 11'd8);
        m_ready = 1'b1; base_addr = 10'h010; len = 11'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (k < 8) chk("addr_seq", i, rom_addr[i], 10'h010 + k);
                chk("valid_seq", i, m_valid[i], (k >= i + 2 && k <= i + 9));
                chk("busy_seq", i, busy[i], (k <= i + 9));
                chk("done_seq", i, done[i], (k == i + 10));
            end
        end
        tick();
        chk("burst_drained", 0, q0.size(), 0);
        chk("burst_drained", 1, q1.size(), 0);

        // Zero-length request: done only, no ROM activity, no output.
        base_addr = 10'h123; len = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("zero_done", i, done[i], (k == 0));
                chk("zero_busy", i, busy[i], 0);
                chk("zero_oce", i, rom_rd_oce[i], 0);
                chk("zero_valid", i, m_valid[i], 0);
            end
        end
        tick();

        for (int v = 0; v < 6; v++) begin
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_words);
        end

        // Abort mid-transfer, then confirm a clean restart.
        push_exp(10'h050, 11'd8);
        m_ready = 1'b1; base_addr = 10'h050; len = 11'd8; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (words[0] < 3 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_wait", 0, (n < 100), 1);
        rst = 1'b1;
        #1;
        check_idle("rst_abort");
        q0.delete();
        q1.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_xfer(10'h020, 11'd2, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
